// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap controller.
//
// Sits between the ROB commit port, the CSR file and the pipeline flush logic.
// At each commit boundary it arbitrates enabled interrupts, synchronous
// exceptions, MRET and WFI. It emits registered one-cycle trap/retire/mret
// pulses and holds a flush request until the pipeline acknowledges it.
//
// Optional feature macro: TRAP_CTRL_WFI_EN
//   defined   - WFI enters SLEEP and the core wakes on an enabled interrupt
//   undefined - WFI commits as a plain retire and sleeping is tied low
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rob_commit_valid    ROB head valid
//   rob_cm_pc           PC of the ROB head
//   rob_cm_exp          head raised an exception with cause rob_cm_ecause
//   rob_cm_mret         head is MRET
//   rob_cm_wfi          head is WFI
//   irq_pending         level pending bits from the CSR file
//   irq_enable          per-line interrupt enables
//   global_ie           global interrupt enable
//   flush_done          pipeline flush acknowledge
//   commit_ready        ROB may commit this cycle (idle state)
//   retired             registered retire pulse
//   trap_valid          registered trap pulse, qualifies ecp/ecause/interrupt
//   ecp, ecause         trap PC and cause, held between traps
//   interrupt           last trap was an interrupt
//   mret_valid          registered MRET pulse
//   flush_req           flush request, held until flush_done
//   sleeping            waiting in WFI sleep

module trap_ctrl #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned NUM_IRQ      = 3,
  parameter int unsigned ECAUSE_WIDTH = 4,
  parameter logic [NUM_IRQ*ECAUSE_WIDTH-1:0] IRQ_CAUSE = {4'd11, 4'd7, 4'd3}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rob_commit_valid,
  input  logic [PC_WIDTH-1:0]     rob_cm_pc,
  input  logic                    rob_cm_exp,
  input  logic [ECAUSE_WIDTH-1:0] rob_cm_ecause,
  input  logic                    rob_cm_mret,
  input  logic                    rob_cm_wfi,
  input  logic [NUM_IRQ-1:0]      irq_pending,
  input  logic [NUM_IRQ-1:0]      irq_enable,
  input  logic                    global_ie,
  input  logic                    flush_done,
  output logic                    commit_ready,
  output logic                    retired,
  output logic                    trap_valid,
  output logic [PC_WIDTH-1:0]     ecp,
  output logic [ECAUSE_WIDTH-1:0] ecause,
  output logic                    interrupt,
  output logic                    mret_valid,
  output logic                    flush_req,
  output logic                    sleeping
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
`ifdef TRAP_CTRL_WFI_EN
  localparam logic [1:0] StSleep = 2'd2;
`endif

  logic [1:0]              state_q, state_d;
  logic                    retired_q, retired_d;
  logic                    trap_valid_q, trap_valid_d;
  logic [PC_WIDTH-1:0]     ecp_q, ecp_d;
  logic [ECAUSE_WIDTH-1:0] ecause_q, ecause_d;
  logic                    interrupt_q, interrupt_d;
  logic                    mret_valid_q, mret_valid_d;
`ifdef TRAP_CTRL_WFI_EN
  logic [PC_WIDTH-1:0]     wake_pc_q, wake_pc_d;
`else
  logic                    unused_wfi;
  assign unused_wfi = rob_cm_wfi;
`endif

  logic [NUM_IRQ-1:0]      irq_masked;
  logic                    irq_any;
  logic                    irq_take;
  logic [ECAUSE_WIDTH-1:0] irq_cause;
  logic                    commit;

  // Highest-index enabled line wins: later loop iterations overwrite earlier ones.
  always_comb begin
    irq_masked = irq_pending & irq_enable;
    irq_any    = |irq_masked;
    irq_take   = irq_any & global_ie;
    irq_cause  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_masked[i]) begin
        irq_cause = IRQ_CAUSE[i*ECAUSE_WIDTH +: ECAUSE_WIDTH];
      end
    end
  end

  assign commit_ready = (state_q == StIdle);
  assign flush_req    = (state_q == StFlush);
`ifdef TRAP_CTRL_WFI_EN
  assign sleeping     = (state_q == StSleep);
`else
  assign sleeping     = 1'b0;
`endif
  assign commit       = rob_commit_valid & commit_ready;

  always_comb begin
    state_d      = state_q;
    retired_d    = 1'b0;
    trap_valid_d = 1'b0;
    mret_valid_d = 1'b0;
    ecp_d        = ecp_q;
    ecause_d     = ecause_q;
    interrupt_d  = interrupt_q;
`ifdef TRAP_CTRL_WFI_EN
    wake_pc_d    = wake_pc_q;
`endif

    case (state_q)
      StIdle: begin
        // Interrupts are only taken at a commit boundary.
        if (commit) begin
          if (irq_take) begin
            // The committing instruction is not retired; it re-executes on return.
            trap_valid_d = 1'b1;
            interrupt_d  = 1'b1;
            ecause_d     = irq_cause;
            ecp_d        = rob_cm_pc;
            state_d      = StFlush;
          end else if (rob_cm_exp) begin
            trap_valid_d = 1'b1;
            interrupt_d  = 1'b0;
            ecause_d     = rob_cm_ecause;
            ecp_d        = rob_cm_pc;
            state_d      = StFlush;
          end else if (rob_cm_mret) begin
            retired_d    = 1'b1;
            mret_valid_d = 1'b1;
            state_d      = StFlush;
`ifdef TRAP_CTRL_WFI_EN
          end else if (rob_cm_wfi) begin
            retired_d    = 1'b1;
            wake_pc_d    = rob_cm_pc + PC_WIDTH'(4);
            state_d      = StSleep;
`endif
          end else begin
            retired_d    = 1'b1;
          end
        end
      end

      StFlush: begin
        if (flush_done) begin
          state_d = StIdle;
        end
      end

`ifdef TRAP_CTRL_WFI_EN
      StSleep: begin
        // Wake on any enabled line; global_ie only decides whether we trap.
        if (irq_any) begin
          if (global_ie) begin
            trap_valid_d = 1'b1;
            interrupt_d  = 1'b1;
            ecause_d     = irq_cause;
            ecp_d        = wake_pc_q;
            state_d      = StFlush;
          end else begin
            state_d      = StIdle;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      retired_q    <= 1'b0;
      trap_valid_q <= 1'b0;
      ecp_q        <= '0;
      ecause_q     <= '0;
      interrupt_q  <= 1'b0;
      mret_valid_q <= 1'b0;
`ifdef TRAP_CTRL_WFI_EN
      wake_pc_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      retired_q    <= retired_d;
      trap_valid_q <= trap_valid_d;
      ecp_q        <= ecp_d;
      ecause_q     <= ecause_d;
      interrupt_q  <= interrupt_d;
      mret_valid_q <= mret_valid_d;
`ifdef TRAP_CTRL_WFI_EN
      wake_pc_q    <= wake_pc_d;
`endif
    end
  end

  assign retired    = retired_q;
  assign trap_valid = trap_valid_q;
  assign ecp        = ecp_q;
  assign ecause     = ecause_q;
  assign interrupt  = interrupt_q;
  assign mret_valid = mret_valid_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed, table-driven bench for trap_ctrl with default parameters.
// Each record drives one cycle of inputs and lists every output expected just
// after the following rising edge.

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_commit_valid;
  logic [31:0] rob_cm_pc;
  logic        rob_cm_exp;
  logic [3:0]  rob_cm_ecause;
  logic        rob_cm_mret;
  logic        rob_cm_wfi;
  logic [2:0]  irq_pending;
  logic [2:0]  irq_enable;
  logic        global_ie;
  logic        flush_done;
  logic        commit_ready;
  logic        retired;
  logic        trap_valid;
  logic [31:0] ecp;
  logic [3:0]  ecause;
  logic        interrupt;
  logic        mret_valid;
  logic        flush_req;
  logic        sleeping;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rob_commit_valid (rob_commit_valid),
    .rob_cm_pc        (rob_cm_pc),
    .rob_cm_exp       (rob_cm_exp),
    .rob_cm_ecause    (rob_cm_ecause),
    .rob_cm_mret      (rob_cm_mret),
    .rob_cm_wfi       (rob_cm_wfi),
    .irq_pending      (irq_pending),
    .irq_enable       (irq_enable),
    .global_ie        (global_ie),
    .flush_done       (flush_done),
    .commit_ready     (commit_ready),
    .retired          (retired),
    .trap_valid       (trap_valid),
    .ecp              (ecp),
    .ecause           (ecause),
    .interrupt        (interrupt),
    .mret_valid       (mret_valid),
    .flush_req        (flush_req),
    .sleeping         (sleeping)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] pc;
    logic        ex;
    logic [3:0]  ec;
    logic        mr;
    logic        wf;
    logic [2:0]  pd;
    logic [2:0]  en;
    logic        g;
    logic        fd;
    logic [42:0] want;
  } vec_t;

  // Output bundle: {ready, retired, trap, intr, mret, flush_req, sleeping, ecause, ecp}
  function automatic logic [42:0] o(input logic cr, ret, tv, intr, mr, fr, sl,
                                    input logic [3:0] ec, input logic [31:0] pc);
    return {cr, ret, tv, intr, mr, fr, sl, ec, pc};
  endfunction

  function automatic vec_t mk(input logic r, v, input logic [31:0] pc,
                              input logic ex, input logic [3:0] ec,
                              input logic mr, wf, input logic [2:0] pd, en,
                              input logic g, fd, input logic [42:0] want);
    vec_t t;
    t.r = r; t.v = v; t.pc = pc; t.ex = ex; t.ec = ec; t.mr = mr; t.wf = wf;
    t.pd = pd; t.en = en; t.g = g; t.fd = fd; t.want = want;
    return t;
  endfunction

  task automatic check(input string name, input logic [42:0] want);
    logic [42:0] got;
    got = {commit_ready, retired, trap_valid, interrupt, mret_valid, flush_req, sleeping,
           ecause, ecp};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b ret=%b tv=%b int=%b mret=%b frq=%b slp=%b ec=%0d ecp=%h | want rdy=%b ret=%b tv=%b int=%b mret=%b frq=%b slp=%b ec=%0d ecp=%h",
               name, got[42], got[41], got[40], got[39], got[38], got[37], got[36],
               got[35:32], got[31:0], want[42], want[41], want[40], want[39], want[38],
               want[37], want[36], want[35:32], want[31:0]);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, compare.
  task automatic apply(input string name, input vec_t t);
    rst              = t.r;
    rob_commit_valid = t.v;
    rob_cm_pc        = t.pc;
    rob_cm_exp       = t.ex;
    rob_cm_ecause    = t.ec;
    rob_cm_mret      = t.mr;
    rob_cm_wfi       = t.wf;
    irq_pending      = t.pd;
    irq_enable       = t.en;
    global_ie        = t.g;
    flush_done       = t.fd;
    @(posedge clk);
    #1;
    check(name, t.want);
  endtask

  vec_t tbl[17];

  initial begin
    //            r  v  pc            ex ec    mr wf pd      en      g  fd
    tbl[0]  = mk(0, 1, 32'h100,      0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 0, o(1,1,0,0,0,0,0, 0, 32'h000));
    tbl[1]  = mk(0, 1, 32'h200,      1, 4'd2, 0, 0, 3'b000, 3'b000, 0, 0, o(0,0,1,0,0,1,0, 2, 32'h200));
    tbl[2]  = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 0, o(0,0,0,0,0,1,0, 2, 32'h200));
    tbl[3]  = mk(0, 1, 32'h999,      1, 4'd1, 0, 0, 3'b000, 3'b000, 0, 0, o(0,0,0,0,0,1,0, 2, 32'h200));
    tbl[4]  = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,0,0,0,0, 2, 32'h200));
    tbl[5]  = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,0,0,0,0, 2, 32'h200));
    tbl[6]  = mk(0, 1, 32'h300,      1, 4'd5, 0, 0, 3'b111, 3'b011, 1, 0, o(0,0,1,1,0,1,0, 7, 32'h300));
    tbl[7]  = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b111, 3'b011, 1, 1, o(1,0,0,1,0,0,0, 7, 32'h300));
    tbl[8]  = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b111, 3'b011, 1, 0, o(1,0,0,1,0,0,0, 7, 32'h300));
    tbl[9]  = mk(0, 1, 32'h400,      0, 4'd0, 1, 0, 3'b111, 3'b111, 0, 0, o(0,1,0,1,1,1,0, 7, 32'h300));
    tbl[10] = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,1,0,0,0, 7, 32'h300));
    tbl[11] = mk(0, 1, 32'h500,      0, 4'd0, 0, 0, 3'b100, 3'b100, 1, 0, o(0,0,1,1,0,1,0,11, 32'h500));
    tbl[12] = mk(0, 1, 32'h600,      0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,1,0,0,0,11, 32'h500));
    tbl[13] = mk(0, 1, 32'h700,      1, 4'hF, 1, 0, 3'b000, 3'b000, 0, 0, o(0,0,1,0,0,1,0,15, 32'h700));
    tbl[14] = mk(0, 0, 32'h0,        0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,0,0,0,0,15, 32'h700));
    tbl[15] = mk(0, 1, 32'h800,      0, 4'd0, 0, 0, 3'b111, 3'b000, 1, 0, o(1,1,0,0,0,0,0,15, 32'h700));
    tbl[16] = mk(0, 1, 32'h804,      0, 4'd0, 0, 0, 3'b010, 3'b010, 0, 0, o(1,1,0,0,0,0,0,15, 32'h700));

    // Reset (two cycles) and reset-state check.
    apply("reset0", mk(1, 0, 32'h0, 0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,32'h0)));
    apply("reset1", mk(1, 1, 32'h5, 1, 4'd9, 0, 0, 3'b111, 3'b111, 1, 1, o(1,0,0,0,0,0,0,0,32'h0)));

    for (int i = 0; i < 17; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Minimum trap-to-next-commit with flush_done tied high.
    apply("min_trap", mk(0, 1, 32'hA00, 1, 4'd4, 0, 0, 3'b000, 3'b000, 0, 1, o(0,0,1,0,0,1,0,4,32'hA00)));
    apply("min_gap",  mk(0, 1, 32'hA04, 0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,0,0,0,0,4,32'hA00)));
    apply("min_next", mk(0, 1, 32'hA04, 0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,1,0,0,0,0,0,4,32'hA00)));

    // Reset in the middle of a flush, then a late flush_done.
    apply("rf_trap",  mk(0, 1, 32'hB00, 1, 4'd6, 0, 0, 3'b000, 3'b000, 0, 0, o(0,0,1,0,0,1,0,6,32'hB00)));
    apply("rf_rst",   mk(1, 0, 32'h0,   0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,32'h0)));
    apply("rf_late",  mk(0, 0, 32'h0,   0, 4'd0, 0, 0, 3'b000, 3'b000, 0, 1, o(1,0,0,0,0,0,0,0,32'h0)));

`ifdef TRAP_CTRL_WFI_EN
    // WFI at the top of the address space; wake PC wraps to zero.
    apply("wfi_enter", mk(0, 1, 32'hFFFF_FFFC, 0, 4'd0, 0, 1, 3'b000, 3'b001, 1, 0,
                          o(0,1,0,0,0,0,1,0,32'h0)));
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("wfi_sleep%0d", i),
            mk(0, 1, 32'hC00, 0, 4'd0, 0, 0, 3'b000, 3'b001, 1, 0, o(0,0,0,0,0,0,1,0,32'h0)));
    end
    apply("wfi_wake",  mk(0, 1, 32'hC00, 0, 4'd0, 0, 0, 3'b001, 3'b001, 1, 0,
                          o(0,0,1,1,0,1,0,3,32'h0)));
    apply("wfi_flush", mk(0, 0, 32'h0,   0, 4'd0, 0, 0, 3'b000, 3'b001, 1, 1,
                          o(1,0,0,1,0,0,0,3,32'h0)));

    // WFI woken with global_ie low: back to idle, no trap.
    apply("wfi2_enter", mk(0, 1, 32'hD00, 0, 4'd0, 0, 1, 3'b000, 3'b010, 0, 0,
                           o(0,1,0,1,0,0,1,3,32'h0)));
    apply("wfi2_wake",  mk(0, 0, 32'h0,   0, 4'd0, 0, 0, 3'b010, 3'b010, 0, 0,
                           o(1,0,0,1,0,0,0,3,32'h0)));
    apply("wfi2_next",  mk(0, 1, 32'hD08, 0, 4'd0, 0, 0, 3'b010, 3'b010, 0, 0,
                           o(1,1,0,1,0,0,0,3,32'h0)));
`else
    // WFI support not built: WFI is a plain retire.
    apply("wfi_plain", mk(0, 1, 32'hE00, 0, 4'd0, 0, 1, 3'b000, 3'b000, 1, 0,
                          o(1,1,0,0,0,0,0,0,32'h0)));
    apply("wfi_after", mk(0, 0, 32'h0,   0, 4'd0, 0, 0, 3'b001, 3'b001, 1, 0,
                          o(1,0,0,0,0,0,0,0,32'h0)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
